// File: rtl/cpu_types_pkg.sv
// Shared types for the cache-to-RAM arbiter: the word type, the RAM handshake state,
// the arbiter FSM states and the grant record.
package cpu_types_pkg;
  localparam int NCPU  = 2;
  localparam int CPU_W = (NCPU > 1) ? $clog2(NCPU) : 1;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic {ARB_IDLE, ARB_SERVE} arb_state_t;

  typedef struct packed {
    logic             is_data;
    logic [CPU_W-1:0] cpu;
  } grant_t;
endpackage

// File: rtl/cache_mem_arbiter_rr_picker.sv
// Round-robin picker: returns the first set request bit found by scanning
// upward from ptr and wrapping modulo N.
module rr_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] idx
);
  logic [W-1:0] cidx;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cidx  = '0;
    for (int k = 0; k < N; k++) begin
      cidx = W'((int'(ptr) + k) % N);
      if (!found && req[cidx]) begin
        found = 1'b1;
        idx   = cidx;
      end
    end
  end
endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates per-core icache/dcache requests onto the single RAM port. Data requests beat
// instruction fetches; within a class a shared round-robin pointer picks the core.
module cache_mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS = NCPU
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      iREN,
  input  word_t [CPUS-1:0]     iaddr,
  output logic [CPUS-1:0]      iwait,
  output word_t [CPUS-1:0]     iload,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  word_t [CPUS-1:0]     daddr,
  input  word_t [CPUS-1:0]     dstore,
  output logic [CPUS-1:0]      dwait,
  output word_t [CPUS-1:0]     dload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output word_t                ramaddr,
  output word_t                ramstore,
  input  word_t                ramload,
  input  ramstate_t            ramstate
);
  arb_state_t       state, state_nxt;
  grant_t           grant, grant_nxt;
  logic [CPU_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [CPUS-1:0]  dreq;
  logic             d_found, i_found;
  logic [CPU_W-1:0] d_idx, i_idx;
  logic             g_live, g_write;

  assign dreq = dREN | dWEN;

  rr_picker #(.N(CPUS), .W(CPU_W)) u_pick_d (
    .req(dreq), .ptr(rr_ptr), .found(d_found), .idx(d_idx)
  );
  rr_picker #(.N(CPUS), .W(CPU_W)) u_pick_i (
    .req(iREN), .ptr(rr_ptr), .found(i_found), .idx(i_idx)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= ARB_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_ptr_nxt;
    end
  end

  // A dport with both REN and WEN high is served as a write.
  assign g_live  = grant.is_data ? dreq[grant.cpu] : iREN[grant.cpu];
  assign g_write = grant.is_data & dWEN[grant.cpu];

  always_comb begin
    state_nxt  = state;
    grant_nxt  = grant;
    rr_ptr_nxt = rr_ptr;
    iwait      = '1;
    dwait      = '1;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    unique case (state)
      ARB_IDLE: begin
        if (d_found) begin
          grant_nxt = '{is_data: 1'b1, cpu: d_idx};
          state_nxt = ARB_SERVE;
        end else if (i_found) begin
          grant_nxt = '{is_data: 1'b0, cpu: i_idx};
          state_nxt = ARB_SERVE;
        end
      end
      ARB_SERVE: begin
        if (!g_live) begin
          state_nxt = ARB_IDLE;
        end else begin
          ramWEN   = g_write;
          ramREN   = !g_write;
          ramaddr  = grant.is_data ? daddr[grant.cpu] : iaddr[grant.cpu];
          ramstore = g_write ? dstore[grant.cpu] : '0;
          // BUSY, FREE and ERROR all hold the request; only ACCESS completes it.
          if (ramstate == ACCESS) begin
            if (grant.is_data) dwait[grant.cpu] = 1'b0;
            else               iwait[grant.cpu] = 1'b0;
            rr_ptr_nxt = (grant.cpu == CPU_W'(CPUS - 1)) ? '0 : grant.cpu + CPU_W'(1);
            state_nxt  = ARB_IDLE;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign iload = {CPUS{ramload}};
  assign dload = {CPUS{ramload}};
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: RAM responder with programmable BUSY/ERROR cycles,
// a transaction-level reference model checked every cycle, and literal checks per scenario.
module tb_cache_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int    CPUS = 2;
  localparam word_t KEY  = 32'hA5A5_0000;

  logic                CLK, nRST;
  logic [CPUS-1:0]     iREN, iwait, dREN, dWEN, dwait;
  word_t [CPUS-1:0]    iaddr, iload, daddr, dstore, dload;
  logic                ramREN, ramWEN;
  word_t               ramaddr, ramstore, ramload;
  ramstate_t           ramstate;

  int busy_n = 0, err_req = 0, ram_cnt = 0, err_used = 0;
  int n_checks = 0, n_fail = 0;

  // reference model state
  bit m_busy = 0, m_data = 0;
  int m_cpu = 0, m_ptr = 0;
  bit comp_data[$];
  int comp_cpu[$];

  cache_mem_arbiter #(.CPUS(CPUS)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign ramload  = ramaddr ^ KEY;
  assign ramstate = !(ramREN | ramWEN) ? FREE :
                    (err_used < err_req) ? ERROR :
                    (ram_cnt >= busy_n) ? ACCESS : BUSY;

  always @(posedge CLK) begin
    if (ramREN | ramWEN) begin
      if (ramstate == ERROR)       err_used <= err_used + 1;
      else if (ramstate == ACCESS) ram_cnt  <= 0;
      else                         ram_cnt  <= ram_cnt + 1;
    end else begin
      ram_cnt  <= 0;
      err_used <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
    end
  endtask

  // Model: at most one outstanding grant; compare, then advance using the inputs
  // the DUT will sample at the coming rising edge.
  always @(negedge CLK) begin
    logic [CPUS-1:0] e_iw, e_dw;
    logic e_ren, e_wen;
    word_t e_addr, e_store;
    bit live, wr, found;
    int c;
    e_iw = '1; e_dw = '1; e_ren = 0; e_wen = 0; e_addr = 0; e_store = 0;
    live = 0; wr = 0; found = 0; c = 0;
    if (nRST && m_busy) begin
      live = m_data ? (dREN[m_cpu] | dWEN[m_cpu]) : iREN[m_cpu];
      if (live) begin
        wr      = m_data && dWEN[m_cpu];
        e_wen   = wr;
        e_ren   = !wr;
        e_addr  = m_data ? daddr[m_cpu] : iaddr[m_cpu];
        e_store = wr ? dstore[m_cpu] : 32'h0;
        if (ramstate == ACCESS) begin
          if (m_data) e_dw[m_cpu] = 1'b0;
          else        e_iw[m_cpu] = 1'b0;
        end
      end
    end
    chk("m_iwait", 32'(iwait), 32'(e_iw));
    chk("m_dwait", 32'(dwait), 32'(e_dw));
    chk("m_ramREN", 32'(ramREN), 32'(e_ren));
    chk("m_ramWEN", 32'(ramWEN), 32'(e_wen));
    chk("m_ramaddr", ramaddr, e_addr);
    chk("m_ramstore", ramstore, e_store);
    for (int p = 0; p < CPUS; p++) begin
      if (!e_iw[p]) chk("m_iload", iload[p], e_addr ^ KEY);
      if (!e_dw[p] && !wr) chk("m_dload", dload[p], e_addr ^ KEY);
    end
    if (!nRST) begin
      m_busy = 0; m_ptr = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < CPUS; k++) begin
        c = (m_ptr + k) % CPUS;
        if (!found && (dREN[c] | dWEN[c])) begin found = 1; m_busy = 1; m_data = 1; m_cpu = c; end
      end
      for (int k = 0; k < CPUS; k++) begin
        c = (m_ptr + k) % CPUS;
        if (!found && iREN[c]) begin found = 1; m_busy = 1; m_data = 0; m_cpu = c; end
      end
    end else if (!live) begin
      m_busy = 0;
    end else if (ramstate == ACCESS) begin
      m_busy = 0;
      m_ptr  = (m_cpu + 1) % CPUS;
      comp_data.push_back(m_data);
      comp_cpu.push_back(m_cpu);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic await_ack(input bit is_data, input int cpu, input int limit, output int cyc);
    cyc = 0;
    for (int k = 1; k <= limit; k++) begin
      tick();
      if ((is_data ? dwait[cpu] : iwait[cpu]) == 1'b0) begin
        cyc = k;
        break;
      end
    end
    chk("ack_seen", 32'(cyc != 0), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, n, acks, wen_cnt, ren_cnt, en_cnt, ack_at, first;
    bit prev_low;
    int order[$];
    nRST = 0; iREN = 2'b11; dREN = 0; dWEN = 0;
    iaddr[0] = 32'h100; iaddr[1] = 32'h200;
    daddr = '0; dstore = '0;

    // 1: reset with iREN=11, then first fetch goes to core 0
    tick(); tick();
    chk("rst_iwait", 32'(iwait), 32'h3);
    chk("rst_dwait", 32'(dwait), 32'h3);
    chk("rst_ramREN", 32'(ramREN), 32'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    nRST = 1;
    tick();
    chk("t1_ramREN", 32'(ramREN), 32'h1);
    chk("t1_ramaddr", ramaddr, 32'h100);
    chk("t1_iwait", 32'(iwait), 32'h2);
    chk("t1_iload0", iload[0], 32'hA5A5_0100);
    tick();
    iREN = 2'b00;

    // 2: data beats instruction
    iREN = 2'b01; dREN = 2'b10; daddr[1] = 32'h300;
    await_ack(1, 1, 10, cyc);
    chk("t2_iwait_held", 32'(iwait[0]), 32'h1);
    chk("t2_dload1", dload[1], 32'hA5A5_0300);
    tick();
    dREN = 2'b00;
    await_ack(0, 0, 10, cyc);
    chk("t2_iload0", iload[0], 32'hA5A5_0100);
    tick();
    iREN = 2'b00;
    n = comp_cpu.size();
    chk("t2_first_is_data", 32'(comp_data[n-2]), 32'h1);
    chk("t2_first_cpu", 32'(comp_cpu[n-2]), 32'h1);
    chk("t2_second_cpu", 32'(comp_cpu[n-1]), 32'h0);

    // bring rr_ptr back to 0
    iREN = 2'b10;
    await_ack(0, 1, 10, cyc);
    tick();
    iREN = 2'b00;

    // 3: both dports held, service order 0,1,0,1
    busy_n = 1; dREN = 2'b11; daddr[0] = 32'h1000; daddr[1] = 32'h1100;
    acks = 0; prev_low = 0;
    for (int k = 0; k < 40 && acks < 4; k++) begin
      tick();
      if (dwait != 2'b11) begin
        chk("t3_not_consecutive", 32'(prev_low), 32'h0);
        chk("t3_single_port", 32'(dwait == 2'b00), 32'h0);
        order.push_back(dwait[0] == 1'b0 ? 0 : 1);
        acks++;
        prev_low = 1;
      end else begin
        prev_low = 0;
      end
    end
    chk("t3_acks", 32'(acks), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < order.size()) chk("t3_order", 32'(order[k]), 32'(k % 2));
    tick();
    dREN = 2'b00;

    // 4: write with BUSY=3
    busy_n = 3; dWEN = 2'b10; daddr[1] = 32'h40; dstore[1] = 32'hDEADBEEF;
    wen_cnt = 0; ren_cnt = 0; ack_at = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ramWEN) wen_cnt++;
      if (ramREN) ren_cnt++;
      if (!dwait[1]) begin
        ack_at = wen_cnt;
        chk("t4_ramstore", ramstore, 32'hDEADBEEF);
        break;
      end
    end
    chk("t4_wen_cycles", 32'(wen_cnt), 32'd4);
    chk("t4_ack_cycle", 32'(ack_at), 32'd4);
    chk("t4_ren_never", 32'(ren_cnt), 32'd0);
    tick();
    dWEN = 2'b00;

    // 5: abort during BUSY leaves rr_ptr alone
    iREN = 2'b01; iaddr[0] = 32'h500;
    tick();
    chk("t5_ramREN_on", 32'(ramREN), 32'h1);
    chk("t5_iwait_a", 32'(iwait[0]), 32'h1);
    tick();
    chk("t5_iwait_b", 32'(iwait[0]), 32'h1);
    iREN = 2'b00;
    tick();
    chk("t5_idle_ramREN", 32'(ramREN), 32'h0);
    chk("t5_idle_iwait", 32'(iwait), 32'h3);
    busy_n = 0; dREN = 2'b11; daddr[0] = 32'h700; daddr[1] = 32'h800;
    first = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (dwait != 2'b11) begin
        first = dwait[0] == 1'b0 ? 0 : 1;
        break;
      end
    end
    chk("t5_next_grant", 32'(first), 32'd0);
    tick();
    dREN = 2'b00;

    // 6: two ERROR cycles, then ACCESS
    err_req = 2; iREN = 2'b10; iaddr[1] = 32'h600;
    en_cnt = 0; ack_at = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ramREN) en_cnt++;
      if (ramstate == ERROR) chk("t6_wait_in_error", 32'(iwait[1]), 32'h1);
      if (!iwait[1]) begin
        ack_at = en_cnt;
        chk("t6_iload1", iload[1], 32'hA5A5_0600);
        break;
      end
    end
    chk("t6_ack_cycle", 32'(ack_at), 32'd3);
    tick();
    iREN = 2'b00; err_req = 0;

    // 7: reset mid-transaction drops the RAM enables at once
    busy_n = 3; dREN = 2'b01; daddr[0] = 32'h900;
    tick(); tick();
    chk("t7_ramREN_pre", 32'(ramREN), 32'h1);
    #1 nRST = 0;
    #1;
    chk("t7_ramREN_rst", 32'(ramREN), 32'h0);
    chk("t7_dwait_rst", 32'(dwait), 32'h3);
    dREN = 2'b00;
    tick();
    nRST = 1;
    tick(); tick();
    chk("t7_idle_after", 32'(ramREN | ramWEN), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
